nodf_module_tracker: RTL and testbench
======================================

# nodf_module_tracker

Synthesizable status tracker for one non-dataflow HLS module that uses the ap_ctrl_hs block handshake. It watches ap_start/ap_ready/ap_done/ap_continue on the DUT top and produces registered counters and timing statistics: transactions, latency, initiation interval and busy cycles. It sits beside the kernel in the co-simulation and debug fabric and is read out after the testbench raises finish.

## Interface
- CNT_W, 32: width of all counters and cycle timestamps.
- DEPTH, 4: maximum number of outstanding start-timestamps kept for latency measurement; must be a power of two and at least 2.
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  kernel start request.
- ap_ready  in  1  kernel has accepted its inputs.
- ap_done  in  1  kernel has completed a transaction.
- ap_continue  in  1  downstream accepts the done; tie to 1 for this module class.
- finish  in  1  end of test; the tracker freezes once it is seen.
- state  out  2  0 IDLE, 1 WAIT_READY, 2 BUSY.
- start_count  out  CNT_W  number of accepted starts.
- done_count  out  CNT_W  number of completed transactions.
- last_latency / min_latency / max_latency  out  CNT_W  latency statistics, in cycles.
- last_interval  out  CNT_W  cycles between the two most recent accepts.
- busy_cycles  out  CNT_W  cycles with at least one transaction outstanding.
- total_cycles  out  CNT_W  cycles since reset, until frozen.
- finished  out  1  sticky; set once finish is seen.
- err_overflow  out  1  sticky; an accept occurred while the timestamp FIFO was full.
- err_underflow  out  1  sticky; a done occurred with no outstanding timestamp.

## Operation
- Accept event is ap_start & ap_ready in the same cycle. Done event is ap_done & ap_continue in the same cycle.
- total_cycles is a free-running cycle count and also serves as the timestamp.
- On accept:
  - start_count increments.
  - The current timestamp is pushed into the FIFO.
  - last_interval is set to the timestamp minus the previous accept timestamp. No update on the first accept.
- On done:
  - done_count increments.
  - The oldest timestamp is popped; last_latency is set to the current timestamp minus the popped value.
  - min_latency and max_latency are updated from that value.
- Accept and done in the same cycle with the FIFO empty: bypass, giving latency 0 and leaving the FIFO empty. With the FIFO non-empty, the pop and push both happen and occupancy is unchanged.
- FIFO full on accept: the count still increments, the push is dropped and err_overflow is set.
- FIFO empty on done (no bypass case): the count still increments, latency is not updated and err_underflow is set.
- Outstanding transactions = start_count − done_count, tracked with a separate CNT_W counter.
- state:
  - BUSY if outstanding > 0.
  - Otherwise WAIT_READY if ap_start = 1.
  - Otherwise IDLE.
- busy_cycles increments in every cycle where state = BUSY.
- All counters saturate at all-ones; they never wrap.
- When finish = 1, finished is set and no further counter, statistic or error update ever occurs. Only reset clears this.

## Timing
- Every output is registered. Statistics reflect an event one cycle after the edge at which it was sampled.
- Reset values: all counters and latencies are 0, except min_latency, which resets to all-ones. finished, both error flags and the FIFO occupancy reset to 0. state resets to IDLE.
- Reset asserted mid-transaction discards all outstanding timestamps. No error is raised.
- In the cycle where finish is first sampled high, events present in that same cycle are not counted.
- No combinational path from inputs to outputs.

## Structure
- Shared package: the state enum (IDLE/WAIT_READY/BUSY) and a saturating-increment function.
- One sub-module, ts_fifo: a DEPTH-entry, CNT_W-wide synchronous FIFO with full/empty flags and a same-cycle push+pop. The top level holds the counters and the statistics logic.

## Test plan
- Single transaction, ap_continue = 1:
  - Stimulus: ap_start with ap_ready at cycle 10, ap_done at cycle 17.
  - Required: start_count = 1, done_count = 1, last_latency = min_latency = max_latency = 7, busy_cycles = 7, state returns to IDLE.
- Pipelined:
  - Stimulus: accepts at cycles 5, 8 and 11; dones at cycles 15, 18 and 24.
  - Required: latencies 10, 10, 13; min = 10, max = 13, last_interval = 3.
- Same-cycle accept and done with the FIFO empty:
  - Required: latency 0, no error flags, occupancy 0.
- Overflow and underflow:
  - Stimulus: 5 accepts with no done (DEPTH = 4).
  - Required: err_overflow = 1, start_count = 5.
  - Then: a done on an empty FIFO after reset. Required: err_underflow = 1, done_count = 1, latency unchanged.
- Finish freeze:
  - Stimulus: raise finish at cycle 30, continue toggling handshakes.
  - Required: finished = 1, total_cycles and all counters constant from then on.
- Saturation and reset:
  - With CNT_W = 4, run 20 accepts. Required: start_count = 15.
  - Assert reset mid-transaction. Required: all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/nodf_module_tracker_pkg.sv
// Shared types and helpers for the ap_ctrl_hs status tracker.
package nodf_module_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_READY = 2'd1,
        BUSY       = 2'd2
    } trk_state_e;

    // Increment that sticks at max_v instead of wrapping; callers cast back to their width.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/nodf_module_tracker_ts_fifo.sv
// Start-timestamp FIFO: DEPTH entries, same-cycle push+pop allowed even when full.
module nodf_module_tracker_ts_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: rtl/nodf_module_tracker.sv
// Handshake tracker for one ap_ctrl_hs kernel: counts, latency, interval and busy statistics.
module nodf_module_tracker
    import nodf_module_tracker_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] start_count,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic [CNT_W-1:0] last_interval,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] total_cycles,
    output logic             finished,
    output logic             err_overflow,
    output logic             err_underflow
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(64'(v), 64'(ALL_ONES)));
    endfunction

    trk_state_e       state_q;
    trk_state_e       state_next;
    logic             is_busy_c;
    logic             run_c;
    logic             accept_c;
    logic             done_c;
    logic             bypass_c;
    logic             fifo_push_c;
    logic             fifo_pop_c;
    logic             lat_valid_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_dout;
    logic [CNT_W-1:0] sample_lat_c;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] prev_ts;
    logic             have_prev;

    // Event decode; everything is gated once finish has been seen.
    always_comb begin
        run_c        = ~finished & ~finish;
        accept_c     = run_c & ap_start & ap_ready;
        done_c       = run_c & ap_done & ap_continue;
        bypass_c     = accept_c & done_c & fifo_empty;
        fifo_push_c  = accept_c & ~bypass_c;
        fifo_pop_c   = done_c & ~fifo_empty;
        lat_valid_c  = bypass_c | fifo_pop_c;
        sample_lat_c = bypass_c ? '0 : (total_cycles - fifo_dout);
        outstanding_next = outstanding;
        if (accept_c && !done_c) begin
            outstanding_next = inc(outstanding);
        end else if (done_c && !accept_c && (outstanding != '0)) begin
            outstanding_next = outstanding - CNT_W'(1);
        end
    end

    nodf_module_tracker_ts_fifo #(
        .DEPTH (DEPTH),
        .W     (CNT_W)
    ) u_ts_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push_c),
        .pop   (fifo_pop_c),
        .din   (total_cycles),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        if (run_c) begin
            if (outstanding_next != '0) state_next = BUSY;
            else if (ap_start)          state_next = WAIT_READY;
            else                        state_next = IDLE;
        end
    end

    always_comb begin
        is_busy_c = (state_q == BUSY);
    end

    assign state = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            start_count   <= '0;
            done_count    <= '0;
            last_latency  <= '0;
            min_latency   <= ALL_ONES;
            max_latency   <= '0;
            last_interval <= '0;
            busy_cycles   <= '0;
            total_cycles  <= '0;
            finished      <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            outstanding   <= '0;
            prev_ts       <= '0;
            have_prev     <= 1'b0;
        end else begin
            if (finish) finished <= 1'b1;
            if (run_c) begin
                total_cycles <= inc(total_cycles);
                outstanding  <= outstanding_next;
                if (is_busy_c) busy_cycles <= inc(busy_cycles);
                if (accept_c) begin
                    start_count <= inc(start_count);
                    if (have_prev) last_interval <= total_cycles - prev_ts;
                    prev_ts   <= total_cycles;
                    have_prev <= 1'b1;
                end
                if (done_c) done_count <= inc(done_count);
                if (lat_valid_c) begin
                    last_latency <= sample_lat_c;
                    if (sample_lat_c < min_latency) min_latency <= sample_lat_c;
                    if (sample_lat_c > max_latency) max_latency <= sample_lat_c;
                end
                // A same-cycle pop frees a slot, so only an unpaired accept can overflow.
                if (accept_c && fifo_full && !fifo_pop_c) err_overflow <= 1'b1;
                if (done_c && fifo_empty && !accept_c)    err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nodf_module_tracker.sv
// Directed bench for nodf_module_tracker: a 32-bit instance and a 4-bit saturation instance on shared stimulus.
module tb_nodf_module_tracker;

    logic clock;
    logic reset;
    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;
    logic finish;

    logic [1:0]  state;
    logic [31:0] start_count, done_count, last_latency, min_latency, max_latency;
    logic [31:0] last_interval, busy_cycles, total_cycles;
    logic        finished, err_overflow, err_underflow;

    logic [1:0]  s_state;
    logic [3:0]  s_start_count, s_done_count, s_last_latency, s_min_latency, s_max_latency;
    logic [3:0]  s_last_interval, s_busy_cycles, s_total_cycles;
    logic        s_finished, s_err_overflow, s_err_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    nodf_module_tracker #(.CNT_W(32), .DEPTH(4)) u_dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .state(state), .start_count(start_count), .done_count(done_count),
        .last_latency(last_latency), .min_latency(min_latency), .max_latency(max_latency),
        .last_interval(last_interval), .busy_cycles(busy_cycles), .total_cycles(total_cycles),
        .finished(finished), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    nodf_module_tracker #(.CNT_W(4), .DEPTH(4)) u_sat (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .state(s_state), .start_count(s_start_count), .done_count(s_done_count),
        .last_latency(s_last_latency), .min_latency(s_min_latency), .max_latency(s_max_latency),
        .last_interval(s_last_interval), .busy_cycles(s_busy_cycles), .total_cycles(s_total_cycles),
        .finished(s_finished), .err_overflow(s_err_overflow), .err_underflow(s_err_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit after each edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle_inputs();
        ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; finish = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_state"},    64'(state), 64'd0);
        chk({pfx, "_start"},    64'(start_count), 64'd0);
        chk({pfx, "_done"},     64'(done_count), 64'd0);
        chk({pfx, "_last_lat"}, 64'(last_latency), 64'd0);
        chk({pfx, "_min_lat"},  64'(min_latency), 64'hFFFF_FFFF);
        chk({pfx, "_max_lat"},  64'(max_latency), 64'd0);
        chk({pfx, "_interval"}, 64'(last_interval), 64'd0);
        chk({pfx, "_busy"},     64'(busy_cycles), 64'd0);
        chk({pfx, "_total"},    64'(total_cycles), 64'd0);
        chk({pfx, "_flags"},    64'({finished, err_overflow, err_underflow}), 64'd0);
        chk({pfx, "_s_start"},  64'(s_start_count), 64'd0);
        chk({pfx, "_s_min"},    64'(s_min_latency), 64'hF);
        chk({pfx, "_s_total"},  64'(s_total_cycles), 64'd0);
    endtask

    initial begin
        ap_continue = 1'b1;
        idle_inputs();
        reset = 1'b1;
        cyc(2);
        chk_reset_vals("por");
        reset = 1'b0;

        // Single transaction: accept, done 7 edges later.
        cyc(3);
        ap_start = 1'b1;
        cyc(1);
        chk("t1_wait_ready", 64'(state), 64'd1);
        ap_ready = 1'b1;
        cyc(1);
        idle_inputs();
        chk("t1_busy_state", 64'(state), 64'd2);
        chk("t1_start", 64'(start_count), 64'd1);
        cyc(6);
        ap_done = 1'b1;
        cyc(1);
        idle_inputs();
        chk("t1_done", 64'(done_count), 64'd1);
        chk("t1_last_lat", 64'(last_latency), 64'd7);
        chk("t1_min_lat", 64'(min_latency), 64'd7);
        chk("t1_max_lat", 64'(max_latency), 64'd7);
        chk("t1_busy_cycles", 64'(busy_cycles), 64'd7);
        chk("t1_idle", 64'(state), 64'd0);
        chk("t1_interval_first", 64'(last_interval), 64'd0);

        // Pipelined: accepts at 5/8/11, dones at 15/18/24.
        do_reset();
        for (int t = 0; t <= 25; t++) begin
            ap_start = (t == 5 || t == 8 || t == 11);
            ap_ready = ap_start;
            ap_done  = (t == 15 || t == 18 || t == 24);
            cyc(1);
            if (t == 15) chk("t2_lat0", 64'(last_latency), 64'd10);
            if (t == 18) chk("t2_lat1", 64'(last_latency), 64'd10);
            if (t == 24) chk("t2_lat2", 64'(last_latency), 64'd13);
        end
        idle_inputs();
        chk("t2_min", 64'(min_latency), 64'd10);
        chk("t2_max", 64'(max_latency), 64'd13);
        chk("t2_interval", 64'(last_interval), 64'd3);
        chk("t2_counts", 64'({start_count, done_count}), {32'd3, 32'd3});
        chk("t2_errs", 64'({err_overflow, err_underflow}), 64'd0);

        // Same-cycle accept and done on an empty FIFO, then a clean follow-up.
        do_reset();
        ap_start = 1'b1; ap_ready = 1'b1; ap_done = 1'b1;
        cyc(1);
        idle_inputs();
        chk("t3_lat0", 64'(last_latency), 64'd0);
        chk("t3_min0", 64'(min_latency), 64'd0);
        chk("t3_counts", 64'({start_count, done_count}), {32'd1, 32'd1});
        chk("t3_errs", 64'({err_overflow, err_underflow}), 64'd0);
        ap_start = 1'b1; ap_ready = 1'b1;
        cyc(1);
        idle_inputs();
        cyc(3);
        ap_done = 1'b1;
        cyc(1);
        idle_inputs();
        chk("t3_followup_lat", 64'(last_latency), 64'd4);
        chk("t3_followup_errs", 64'({err_overflow, err_underflow}), 64'd0);

        // Overflow: fifth accept with DEPTH=4 and nothing popped.
        do_reset();
        ap_start = 1'b1; ap_ready = 1'b1;
        cyc(4);
        chk("t4_no_ovf_at_4", 64'(err_overflow), 64'd0);
        cyc(1);
        idle_inputs();
        chk("t4_ovf", 64'(err_overflow), 64'd1);
        chk("t4_start5", 64'(start_count), 64'd5);

        // Underflow: done on an empty FIFO right after reset.
        do_reset();
        ap_done = 1'b1;
        cyc(1);
        idle_inputs();
        chk("t4_unf", 64'(err_underflow), 64'd1);
        chk("t4_unf_done", 64'(done_count), 64'd1);
        chk("t4_unf_last", 64'(last_latency), 64'd0);
        chk("t4_unf_min", 64'(min_latency), 64'hFFFF_FFFF);
        chk("t4_unf_ovf", 64'(err_overflow), 64'd0);

        // Finish freeze: events in the finish cycle and afterwards are ignored.
        do_reset();
        ap_start = 1'b1; ap_ready = 1'b1;
        cyc(1);
        idle_inputs();
        cyc(28);
        chk("t5_pre_total", 64'(total_cycles), 64'd29);
        finish = 1'b1; ap_start = 1'b1; ap_ready = 1'b1; ap_done = 1'b1;
        cyc(1);
        chk("t5_finished", 64'(finished), 64'd1);
        chk("t5_total_frozen", 64'(total_cycles), 64'd29);
        chk("t5_counts_frozen", 64'({start_count, done_count}), {32'd1, 32'd0});
        finish = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ap_start = i[0]; ap_ready = 1'b1; ap_done = ~i[0];
            cyc(1);
        end
        idle_inputs();
        chk("t5_total_still", 64'(total_cycles), 64'd29);
        chk("t5_start_still", 64'(start_count), 64'd1);
        chk("t5_done_still", 64'(done_count), 64'd0);
        chk("t5_busy_still", 64'(busy_cycles), 64'd28);
        chk("t5_lat_still", 64'(last_latency), 64'd0);
        chk("t5_state_still", 64'(state), 64'd2);
        chk("t5_errs_still", 64'({finished, err_overflow, err_underflow}), 64'b100);

        // Saturation with CNT_W=4, then reset in the middle of outstanding work.
        do_reset();
        ap_start = 1'b1; ap_ready = 1'b1;
        cyc(20);
        chk("t6_sat_start", 64'(s_start_count), 64'd15);
        chk("t6_sat_total", 64'(s_total_cycles), 64'd15);
        chk("t6_wide_start", 64'(start_count), 64'd20);
        reset = 1'b1;
        cyc(1);
        chk_reset_vals("t6_midreset");
        reset = 1'b0;
        idle_inputs();
        ap_start = 1'b1; ap_ready = 1'b1;
        cyc(1);
        idle_inputs();
        cyc(1);
        ap_done = 1'b1;
        cyc(1);
        idle_inputs();
        chk("t6_post_lat", 64'(last_latency), 64'd2);
        chk("t6_post_errs", 64'({err_overflow, err_underflow}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
